axil_master: RTL and testbench
==============================

# axil_master

Downstream bridge that turns the core-style data request channel (addr/wdata/ren/wen/tag) into single AXI4-Lite master transactions for addresses outside local RAM, returning a tagged response. One transaction outstanding at a time. Sits between the I/O bus decoder and the external AXI4-Lite interconnect.

## Interface
- AXI_PROT, 3'b000, constant driven on m_awprot/m_arprot
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- req_addr  in  32  byte address
- req_wdata  in  32  write data
- req_ren  in  1  read request
- req_wen  in  4  byte write enables; any bit set = write request
- req_tag  in  11  request tag, echoed on response
- req_accept  out  1  request taken this cycle when high with a request present
- resp_val  out  1  one-cycle response strobe
- resp_error  out  1  slave returned non-OKAY (qualified by resp_val)
- resp_rdata  out  32  read data (0 for writes)
- resp_tag  out  11  tag of completing request
- m_awaddr/m_awprot/m_awvalid  out  32/3/1; m_awready  in  1
- m_wdata/m_wstrb/m_wvalid  out  32/4/1; m_wready  in  1
- m_bresp  in  2; m_bvalid  in  1; m_bready  out  1
- m_araddr/m_arprot/m_arvalid  out  32/3/1; m_arready  in  1
- m_rdata  in  32; m_rresp  in  2; m_rvalid  in  1; m_rready  out  1

## Operation
- States: IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, RESP.
- IDLE: req_accept=1 (combinational from state). Request present = req_ren | (|req_wen). On request: latch addr (bits [1:0] forced 0), wdata, wen, tag; go WR_REQ if |req_wen else RD_ADDR. Both ren and wen set: treated as write.
- RD_ADDR: m_arvalid=1; on m_arready -> RD_DATA.
- RD_DATA: m_rready=1; on m_rvalid latch m_rdata, error = (m_rresp!=2'b00) -> RESP.
- WR_REQ: m_awvalid and m_wvalid both raised on entry; each drops independently after its own handshake (aw_done/w_done flags); both done (including same cycle) -> WR_RESP.
- WR_RESP: m_bready=1; on m_bvalid latch error = (m_bresp!=2'b00), rdata=0 -> RESP.
- RESP: resp_val=1 for exactly one cycle with latched rdata/error/tag; req_accept=0; -> IDLE.
- SLVERR and DECERR both map to resp_error=1; no retry.
- All AXI valids/readies and resp_val are registered outputs (no combinational path from AXI inputs to AXI outputs).

## Timing
- Reset values: state IDLE, req_accept=1, resp_val=0, resp_error=0, resp_rdata=0, resp_tag=0, all m_*valid=0, m_bready=0, m_rready=0, addresses/data 0.
- Zero-wait slave: accept at T0, AR (or AW+W) handshake T1, R (or B) handshake T2, resp_val T3, next accept T4.
- Each slave wait cycle adds one cycle; no timeout.
- Request when req_accept=0 is ignored; requester holds it until accepted.
- Valids never drop before ready (AXI rule); payload stable while valid.
- Reset asserted mid-transaction: immediate return to IDLE, all valids low, no response produced; slave shares reset.

## Structure
- Package axil_pkg: AXI resp codes (OKAY=2'b00, EXOKAY, SLVERR, DECERR), state enum, tag width constant (11).
- Single module, no sub-module; skid buffering not required at one outstanding transaction.

## Test plan
- Read 0x8000_1006, tag 0x12A, slave rdata 0xDEADBEEF OKAY, no waits -> araddr 0x8000_1004, resp_val at T3, rdata 0xDEADBEEF, tag 0x12A, error 0.
- Write 0x8000_0010 data 0xA5A5_0001 wen 4'b0011; awready 3 cycles before wready -> awvalid drops first, wvalid held, wstrb 0011, one resp_val, rdata 0.
- Read with m_rresp=2'b10 -> resp_val with resp_error=1, rdata latched.
- ren=1 and wen=4'hF together -> write issued, no AR, one response.
- Back-to-back requests held on input -> second accepted only at T4, tags returned in order.
- rst_n low while in RD_DATA with arvalid already done -> all outputs at reset values next edge, no resp_val, req_accept=1 after release.

Source files
------------

// File: rtl/axil_pkg.sv
// Shared types and constants for the core-request to AXI4-Lite master bridge.
package axil_pkg;

   localparam int unsigned TAG_W      = 11;
   localparam logic [2:0]  AXI_PROT   = 3'b000;
   localparam logic [31:0] ADDR_ALIGN = 32'hFFFF_FFFC;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_EXOKAY = 2'b01;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   typedef enum logic [2:0] {
      IDLE,
      RD_ADDR,
      RD_DATA,
      WR_REQ,
      WR_RESP,
      RESP
   } state_t;

   // Anything other than OKAY is reported as an error; no retry is attempted.
   function automatic logic is_err_resp(input logic [1:0] r);
      logic err;
      case (r)
         RESP_OKAY:                err = 1'b0;
         RESP_EXOKAY:              err = 1'b1;
         RESP_SLVERR, RESP_DECERR: err = 1'b1;
         default:                  err = 1'b1;
      endcase
      return err;
   endfunction

endpackage

// File: rtl/axil_master.sv
// Bridges tagged core data requests onto single AXI4-Lite transactions,
// one outstanding at a time, and returns a one-cycle tagged response.
module axil_master
   import axil_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic [31:0]      req_addr,
   input  logic [31:0]      req_wdata,
   input  logic             req_ren,
   input  logic [3:0]       req_wen,
   input  logic [TAG_W-1:0] req_tag,
   output logic             req_accept,
   output logic             resp_val,
   output logic             resp_error,
   output logic [31:0]      resp_rdata,
   output logic [TAG_W-1:0] resp_tag,
   output logic [31:0]      m_awaddr,
   output logic [2:0]       m_awprot,
   output logic             m_awvalid,
   input  logic             m_awready,
   output logic [31:0]      m_wdata,
   output logic [3:0]       m_wstrb,
   output logic             m_wvalid,
   input  logic             m_wready,
   input  logic [1:0]       m_bresp,
   input  logic             m_bvalid,
   output logic             m_bready,
   output logic [31:0]      m_araddr,
   output logic [2:0]       m_arprot,
   output logic             m_arvalid,
   input  logic             m_arready,
   input  logic [31:0]      m_rdata,
   input  logic [1:0]       m_rresp,
   input  logic             m_rvalid,
   output logic             m_rready
);

   state_t           state;
   logic [31:0]      addr_q;
   logic [31:0]      wdata_q;
   logic [3:0]       wen_q;
   logic [TAG_W-1:0] tag_q;
   logic             aw_done;
   logic             w_done;
   logic             aw_fin;
   logic             w_fin;
   logic             req_present;
   logic             req_write;

   assign req_present = req_ren | (|req_wen);
   assign req_write   = |req_wen;

   // A channel counts as finished if it completed earlier or handshakes now.
   assign aw_fin = aw_done | (m_awvalid & m_awready);
   assign w_fin  = w_done  | (m_wvalid  & m_wready);

   assign req_accept = (state == IDLE);
   assign m_awaddr   = addr_q;
   assign m_araddr   = addr_q;
   assign m_wdata    = wdata_q;
   assign m_wstrb    = wen_q;
   assign m_awprot   = AXI_PROT;
   assign m_arprot   = AXI_PROT;
   assign resp_tag   = tag_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         addr_q     <= '0;
         wdata_q    <= '0;
         wen_q      <= '0;
         tag_q      <= '0;
         aw_done    <= 1'b0;
         w_done     <= 1'b0;
         m_awvalid  <= 1'b0;
         m_wvalid   <= 1'b0;
         m_bready   <= 1'b0;
         m_arvalid  <= 1'b0;
         m_rready   <= 1'b0;
         resp_val   <= 1'b0;
         resp_error <= 1'b0;
         resp_rdata <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (req_present) begin
                  addr_q  <= req_addr & ADDR_ALIGN;
                  wdata_q <= req_wdata;
                  wen_q   <= req_wen;
                  tag_q   <= req_tag;
                  if (req_write) begin
                     m_awvalid <= 1'b1;
                     m_wvalid  <= 1'b1;
                     aw_done   <= 1'b0;
                     w_done    <= 1'b0;
                     state     <= WR_REQ;
                  end else begin
                     m_arvalid <= 1'b1;
                     state     <= RD_ADDR;
                  end
               end
            end

            RD_ADDR: begin
               if (m_arready) begin
                  m_arvalid <= 1'b0;
                  m_rready  <= 1'b1;
                  state     <= RD_DATA;
               end
            end

            RD_DATA: begin
               if (m_rvalid) begin
                  m_rready   <= 1'b0;
                  resp_rdata <= m_rdata;
                  resp_error <= is_err_resp(m_rresp);
                  resp_val   <= 1'b1;
                  state      <= RESP;
               end
            end

            WR_REQ: begin
               if (m_awvalid && m_awready) begin
                  m_awvalid <= 1'b0;
                  aw_done   <= 1'b1;
               end
               if (m_wvalid && m_wready) begin
                  m_wvalid <= 1'b0;
                  w_done   <= 1'b1;
               end
               if (aw_fin && w_fin) begin
                  m_bready <= 1'b1;
                  state    <= WR_RESP;
               end
            end

            WR_RESP: begin
               if (m_bvalid) begin
                  m_bready   <= 1'b0;
                  resp_rdata <= '0;
                  resp_error <= is_err_resp(m_bresp);
                  resp_val   <= 1'b1;
                  state      <= RESP;
               end
            end

            RESP: begin
               resp_val <= 1'b0;
               state    <= IDLE;
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_axil_master.sv
// Randomised bench for axil_master: a schedule-based transaction model predicts
// every handshake window and response, and drives a matching AXI4-Lite slave.
module tb_axil_master;
   import axil_pkg::*;

   logic        clk       = 1'b0;
   logic        rst_n     = 1'b0;
   logic [31:0] req_addr  = '0;
   logic [31:0] req_wdata = '0;
   logic        req_ren   = 1'b0;
   logic [3:0]  req_wen   = '0;
   logic [10:0] req_tag   = '0;
   logic        req_accept, resp_val, resp_error;
   logic [31:0] resp_rdata;
   logic [10:0] resp_tag;
   logic [31:0] m_awaddr, m_wdata, m_araddr;
   logic [2:0]  m_awprot, m_arprot;
   logic        m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready;
   logic [3:0]  m_wstrb;
   logic        m_awready = 1'b0, m_wready = 1'b0, m_bvalid = 1'b0;
   logic        m_arready = 1'b0, m_rvalid = 1'b0;
   logic [1:0]  m_bresp = '0, m_rresp = '0;
   logic [31:0] m_rdata = '0;

   axil_master dut (
      .clk(clk), .rst_n(rst_n),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_ren(req_ren),
      .req_wen(req_wen), .req_tag(req_tag), .req_accept(req_accept),
      .resp_val(resp_val), .resp_error(resp_error), .resp_rdata(resp_rdata),
      .resp_tag(resp_tag),
      .m_awaddr(m_awaddr), .m_awprot(m_awprot), .m_awvalid(m_awvalid), .m_awready(m_awready),
      .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
      .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
      .m_araddr(m_araddr), .m_arprot(m_arprot), .m_arvalid(m_arvalid), .m_arready(m_arready),
      .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready)
   );

   // One request plus the slave behaviour to apply to it: a_w = AR/AW wait,
   // w_w = W wait, d_w = R/B wait (cycles of ready/valid delay).
   typedef struct {
      logic        ren;
      logic [3:0]  wen;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [10:0] tag;
      int          a_w;
      int          w_w;
      int          d_w;
      logic [31:0] rdata;
      logic [1:0]  resp;
   } item_t;

   typedef struct {
      logic [10:0] tag;
      logic [31:0] rdata;
      logic        err;
      int          d;
      int          at;
   } obs_t;

   item_t       stim_q[$];
   obs_t        dut_q[$];
   item_t       cur;
   int          vectors = 0, miscompares = 0;
   int          edge_cnt = 0, acc_e = 0, mdl_dresp = 0;
   bit          busy = 1'b0, r_sent = 1'b0, b_sent = 1'b0;
   int          ar_cnt = 0, aw_cnt = 0, w_cnt = 0, aw_d = 0, w_d = 0;
   logic [31:0] last_araddr = '0, last_awaddr = '0, last_wdata = '0;
   logic [3:0]  last_wstrb = '0;

   always #5 clk = ~clk;
   always @(posedge clk) edge_cnt <= edge_cnt + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s @edge %0d: got 0x%08h, expected 0x%08h", name, edge_cnt, act, exp);
      end
   endtask

   task automatic push(input logic ren, input logic [3:0] wen, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [10:0] tag, input int a_w,
                       input int w_w, input int d_w, input logic [31:0] rdata,
                       input logic [1:0] resp);
      item_t it;
      it.ren = ren; it.wen = wen; it.addr = addr; it.wdata = wdata; it.tag = tag;
      it.a_w = a_w; it.w_w = w_w; it.d_w = d_w; it.rdata = rdata; it.resp = resp;
      stim_q.push_back(it);
   endtask

   task automatic wait_idle(input int limit);
      int n;
      n = 0;
      while ((stim_q.size() != 0 || busy) && n < limit) begin
         @(posedge clk);
         n++;
      end
      chk("idle_timeout", 32'(n < limit), 32'd1);
   endtask

   // Model, checker, slave and requester, all evaluated mid-cycle on the falling edge.
   initial begin : tick
      int d, mx, d_resp;
      bit wr, fin;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            busy = 1'b0;
            {m_awready, m_wready, m_bvalid, m_arready, m_rvalid} = '0;
            req_ren = 1'b0;
            req_wen = '0;
            chk("rst_req_accept", 32'(req_accept), 32'd1);
            chk("rst_resp_val", 32'(resp_val), 32'd0);
            chk("rst_valids", 32'({m_awvalid, m_wvalid, m_arvalid, m_bready, m_rready}), 32'd0);
         end else begin
            d      = edge_cnt - acc_e;
            wr     = |cur.wen;
            mx     = (cur.a_w > cur.w_w) ? cur.a_w : cur.w_w;
            d_resp = 2 + cur.d_w + (wr ? mx : cur.a_w);
            fin    = busy && (d == d_resp);

            chk("req_accept", 32'(req_accept), 32'(!busy));
            chk("resp_val", 32'(resp_val), 32'(fin));
            chk("m_arvalid", 32'(m_arvalid), 32'(busy && !wr && d <= cur.a_w));
            chk("m_rready", 32'(m_rready),
                32'(busy && !wr && d > cur.a_w && d <= cur.a_w + 1 + cur.d_w));
            chk("m_awvalid", 32'(m_awvalid), 32'(busy && wr && d <= cur.a_w));
            chk("m_wvalid", 32'(m_wvalid), 32'(busy && wr && d <= cur.w_w));
            chk("m_bready", 32'(m_bready), 32'(busy && wr && d > mx && d <= mx + 1 + cur.d_w));
            chk("m_prot", 32'({m_awprot, m_arprot}), 32'd0);
            if (m_arvalid) chk("m_araddr", m_araddr, cur.addr & 32'hFFFF_FFFC);
            if (m_awvalid) chk("m_awaddr", m_awaddr, cur.addr & 32'hFFFF_FFFC);
            if (m_wvalid) begin
               chk("m_wdata", m_wdata, cur.wdata);
               chk("m_wstrb", 32'(m_wstrb), 32'(cur.wen));
            end
            if (fin) begin
               chk("resp_tag", 32'(resp_tag), 32'(cur.tag));
               chk("resp_rdata", resp_rdata, wr ? 32'h0 : cur.rdata);
               chk("resp_error", 32'(resp_error), 32'(cur.resp != 2'b00));
               mdl_dresp = d_resp;
            end
            if (resp_val) dut_q.push_back('{resp_tag, resp_rdata, resp_error, d, edge_cnt});

            m_arready = busy && !wr && d == cur.a_w;
            m_awready = busy && wr && d == cur.a_w;
            m_wready  = busy && wr && d == cur.w_w;
            m_rvalid  = busy && !wr && !r_sent && d >= cur.a_w + 1 + cur.d_w;
            m_bvalid  = busy && wr && !b_sent && d >= mx + 1 + cur.d_w;
            m_rdata   = m_rvalid ? cur.rdata : $urandom;
            m_rresp   = m_rvalid ? cur.resp : 2'($urandom);
            m_bresp   = m_bvalid ? cur.resp : 2'($urandom);
            if (m_arready && m_arvalid) begin
               ar_cnt++;
               last_araddr = m_araddr;
            end
            if (m_awready && m_awvalid) begin
               aw_cnt++;
               last_awaddr = m_awaddr;
               aw_d = d;
            end
            if (m_wready && m_wvalid) begin
               w_cnt++;
               last_wdata = m_wdata;
               last_wstrb = m_wstrb;
               w_d = d;
            end
            if (m_rvalid && m_rready) r_sent = 1'b1;
            if (m_bvalid && m_bready) b_sent = 1'b1;

            // The requester holds its head request until the bridge is free.
            if (stim_q.size() > 0) begin
               req_ren   = stim_q[0].ren;
               req_wen   = stim_q[0].wen;
               req_addr  = stim_q[0].addr;
               req_wdata = stim_q[0].wdata;
               req_tag   = stim_q[0].tag;
               if (!busy) begin
                  cur    = stim_q.pop_front();
                  busy   = 1'b1;
                  acc_e  = edge_cnt + 1;
                  r_sent = 1'b0;
                  b_sent = 1'b0;
               end
            end else begin
               req_ren   = 1'b0;
               req_wen   = '0;
               req_addr  = $urandom;
               req_wdata = $urandom;
               req_tag   = 11'($urandom);
            end
            if (fin) busy = 1'b0;
         end
      end
   end

   initial begin : main
      int   n0, a0, w0, r0, k;
      logic [3:0] wen;
      obs_t o, o2;

      repeat (2) @(posedge clk);
      #2;
      chk("reset_req_accept", 32'(req_accept), 32'd1);
      chk("reset_resp", 32'({resp_val, resp_error}), 32'd0);
      chk("reset_resp_rdata", resp_rdata, 32'd0);
      chk("reset_resp_tag", 32'(resp_tag), 32'd0);
      chk("reset_addr", m_awaddr | m_araddr | m_wdata, 32'd0);
      chk("reset_wstrb", 32'(m_wstrb), 32'd0);
      @(posedge clk);
      #2 rst_n = 1'b1;

      // Zero-wait read of an unaligned address.
      push(1'b1, 4'h0, 32'h8000_1006, 32'h0, 11'h12A, 0, 0, 0, 32'hDEAD_BEEF, 2'b00);
      wait_idle(40);
      chk("t1_resp_count", 32'(dut_q.size()), 32'd1);
      if (dut_q.size() > 0) begin
         o = dut_q[$];
         chk("t1_tag", 32'(o.tag), 32'h12A);
         chk("t1_rdata", o.rdata, 32'hDEAD_BEEF);
         chk("t1_error", 32'(o.err), 32'd0);
         chk("t1_latency", 32'(o.d), 32'd2);
      end
      chk("t1_model_latency", 32'(mdl_dresp), 32'd2);
      chk("t1_araddr", last_araddr, 32'h8000_1004);

      // Write where AW completes three cycles before W.
      n0 = dut_q.size();
      push(1'b0, 4'b0011, 32'h8000_0010, 32'hA5A5_0001, 11'h055, 0, 3, 0, 32'hFFFF_FFFF, 2'b00);
      wait_idle(40);
      chk("t2_resp_count", 32'(dut_q.size() - n0), 32'd1);
      chk("t2_awaddr", last_awaddr, 32'h8000_0010);
      chk("t2_wdata", last_wdata, 32'hA5A5_0001);
      chk("t2_wstrb", 32'(last_wstrb), 32'b0011);
      chk("t2_aw_cycle", 32'(aw_d), 32'd0);
      chk("t2_w_cycle", 32'(w_d), 32'd3);
      chk("t2_model_latency", 32'(mdl_dresp), 32'd5);
      if (dut_q.size() > n0) chk("t2_rdata", dut_q[$].rdata, 32'd0);

      // Read answered with SLVERR.
      push(1'b1, 4'h0, 32'h9000_0020, 32'h0, 11'h3FF, 1, 0, 2, 32'h1234_5678, 2'b10);
      wait_idle(40);
      if (dut_q.size() > 0) begin
         o = dut_q[$];
         chk("t3_error", 32'(o.err), 32'd1);
         chk("t3_rdata", o.rdata, 32'h1234_5678);
         chk("t3_tag", 32'(o.tag), 32'h3FF);
      end

      // Read and write enables together: treated as a write only.
      n0 = dut_q.size(); a0 = ar_cnt; w0 = aw_cnt; r0 = w_cnt;
      push(1'b1, 4'hF, 32'h8000_0100, 32'hCAFE_F00D, 11'h077, 0, 0, 0, 32'h5555_5555, 2'b00);
      wait_idle(40);
      chk("t4_no_ar", 32'(ar_cnt - a0), 32'd0);
      chk("t4_aw", 32'(aw_cnt - w0), 32'd1);
      chk("t4_w", 32'(w_cnt - r0), 32'd1);
      chk("t4_resp_count", 32'(dut_q.size() - n0), 32'd1);

      // Back-to-back held requests: four cycles apart, tags in order.
      n0 = dut_q.size();
      push(1'b1, 4'h0, 32'h8000_2000, 32'h0, 11'h101, 0, 0, 0, 32'h0000_1111, 2'b00);
      push(1'b1, 4'h0, 32'h8000_2004, 32'h0, 11'h102, 0, 0, 0, 32'h0000_2222, 2'b00);
      wait_idle(60);
      chk("t5_resp_count", 32'(dut_q.size() - n0), 32'd2);
      if (dut_q.size() >= n0 + 2) begin
         o  = dut_q[n0];
         o2 = dut_q[n0 + 1];
         chk("t5_tag_first", 32'(o.tag), 32'h101);
         chk("t5_tag_second", 32'(o2.tag), 32'h102);
         chk("t5_spacing", 32'(o2.at - o.at), 32'd4);
      end

      // Reset while waiting in the read-data phase.
      n0 = dut_q.size();
      push(1'b1, 4'h0, 32'h8000_3000, 32'h0, 11'h0AA, 0, 0, 15, 32'h7777_7777, 2'b00);
      k = 0;
      while (!(busy && (edge_cnt - acc_e) >= 3) && k < 50) begin
         @(posedge clk);
         k++;
      end
      chk("t6_reached_rd_data", 32'(k < 50), 32'd1);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("t6_req_accept", 32'(req_accept), 32'd1);
      chk("t6_valids", 32'({m_arvalid, m_rready, m_awvalid, m_wvalid, m_bready, resp_val}), 32'd0);
      chk("t6_araddr", m_araddr, 32'd0);
      chk("t6_resp_tag", 32'(resp_tag), 32'd0);
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;
      repeat (5) @(posedge clk);
      chk("t6_no_response", 32'(dut_q.size()), 32'(n0));

      // Randomised mix of reads, writes and combined requests.
      for (int i = 0; i < 40; i++) begin
         k   = $urandom_range(0, 2);
         wen = (k == 0) ? 4'h0 : 4'($urandom_range(1, 15));
         push(k != 1, wen, $urandom, $urandom, 11'($urandom), $urandom_range(0, 3),
              $urandom_range(0, 3), $urandom_range(0, 3), $urandom, 2'($urandom));
      end
      wait_idle(800);
      repeat (3) @(posedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
